// File: rtl/dateinfo_pkg.sv
// Shared calendar definitions: FSM state type, BCD constants and the
// digit-wise BCD helpers used by both the stepper and its date-step logic.
package dateinfo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    EMIT_D,
    EMIT_M,
    EMIT_Y
  } state_t;

  localparam logic [7:0] BCD_ONE = 8'h01;
  localparam logic [7:0] BCD_JAN = 8'h01;
  localparam logic [7:0] BCD_FEB = 8'h02;
  localparam logic [7:0] BCD_MAR = 8'h03;
  localparam logic [7:0] BCD_APR = 8'h04;
  localparam logic [7:0] BCD_MAY = 8'h05;
  localparam logic [7:0] BCD_JUN = 8'h06;
  localparam logic [7:0] BCD_JUL = 8'h07;
  localparam logic [7:0] BCD_AUG = 8'h08;
  localparam logic [7:0] BCD_SEP = 8'h09;
  localparam logic [7:0] BCD_OCT = 8'h10;
  localparam logic [7:0] BCD_NOV = 8'h11;
  localparam logic [7:0] BCD_DEC = 8'h12;
  localparam logic [7:0] BCD_28  = 8'h28;
  localparam logic [7:0] BCD_29  = 8'h29;
  localparam logic [7:0] BCD_30  = 8'h30;
  localparam logic [7:0] BCD_31  = 8'h31;
  localparam logic [7:0] BCD_99  = 8'h99;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == BCD_99)          r = 8'h00;
    else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
    else                      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Two-digit BCD decrement, 00 wraps to 99.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h00)           r = BCD_99;
    else if (v[3:0] == 4'd0)  r = {v[7:4] - 4'd1, 4'd9};
    else                      r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // Both nibbles are decimal digits.
  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // year mod 4 == 0 from the digits: even tens needs units 0/4/8,
  // odd tens needs units 2/6.
  function automatic logic leap_year(input logic [7:0] y);
    logic r;
    if (!y[4]) r = (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
    else       r = (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
    return r;
  endfunction

  // Length of a month in BCD, February corrected for leap years.
  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [7:0] y);
    logic [7:0] r;
    case (m)
      BCD_APR, BCD_JUN, BCD_SEP, BCD_NOV: r = BCD_30;
      BCD_FEB:                            r = leap_year(y) ? BCD_29 : BCD_28;
      default:                            r = BCD_31;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_date_step.sv
// Combinational one-day step of a BCD date/month/year, forward or backward.
module bcd_date_step
  import dateinfo_pkg::*;
(
  input  logic [7:0] date,
  input  logic [7:0] month,
  input  logic [7:0] year,
  input  logic       down,
  output logic [7:0] next_date,
  output logic [7:0] next_month,
  output logic [7:0] next_year
);

  // Roll date into month and month into year; backward steps take the
  // length of the month being entered.
  always_comb begin
    next_date  = date;
    next_month = month;
    next_year  = year;
    if (!down) begin
      if (date < days_in_month(month, year)) begin
        next_date = bcd_inc(date);
      end else begin
        next_date = BCD_ONE;
        if (month == BCD_DEC) begin
          next_month = BCD_JAN;
          next_year  = bcd_inc(year);
        end else begin
          next_month = bcd_inc(month);
        end
      end
    end else begin
      if (date > BCD_ONE) begin
        next_date = bcd_dec(date);
      end else begin
        if (month == BCD_JAN) begin
          next_month = BCD_DEC;
          next_year  = bcd_dec(year);
        end else begin
          next_month = bcd_dec(month);
        end
        next_date = days_in_month(next_month, next_year);
      end
    end
  end

endmodule

// File: rtl/date_stepper.sv
// BCD calendar register with day stepping, validated loads and a
// date/month/year byte stream after every accepted change.
module date_stepper
  import dateinfo_pkg::*;
#(
  parameter logic [7:0] RESET_DATE  = 8'h01,
  parameter logic [7:0] RESET_MONTH = 8'h01,
  parameter logic [7:0] RESET_YEAR  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_date,
  input  logic [7:0] load_month,
  input  logic [7:0] load_year,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] date,
  output logic [7:0] month,
  output logic [7:0] year,
  output logic       busy,
  output logic       err,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready
);

  state_t     state;
  logic       cmd_load;
  logic       cmd_down;
  logic [7:0] ld_date, ld_month, ld_year;
  logic [7:0] step_date, step_month, step_year;
  logic [7:0] nxt_date, nxt_month, nxt_year;
  logic       load_ok;

  bcd_date_step u_step (
    .date       (date),
    .month      (month),
    .year       (year),
    .down       (cmd_down),
    .next_date  (step_date),
    .next_month (step_month),
    .next_year  (step_year)
  );

  // A load is accepted only if every field is a real calendar value.
  always_comb begin
    load_ok = bcd_ok(load_year) && bcd_ok(load_month) && bcd_ok(load_date) &&
              (load_month >= BCD_JAN) && (load_month <= BCD_DEC) &&
              (load_date >= BCD_ONE) &&
              (load_date <= days_in_month(load_month, load_year));
  end

  // Value committed in STEP: the captured load or the stepped date.
  always_comb begin
    nxt_date  = cmd_load ? ld_date  : step_date;
    nxt_month = cmd_load ? ld_month : step_month;
    nxt_year  = cmd_load ? ld_year  : step_year;
  end

  // Hold load operands from the accept edge until STEP commits them.
  always_ff @(posedge clk) begin
    if (state == IDLE && load) begin
      ld_date  <= load_date;
      ld_month <= load_month;
      ld_year  <= load_year;
    end
  end

  // Command FSM: accept in IDLE, commit in STEP, then stream three bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      date      <= RESET_DATE;
      month     <= RESET_MONTH;
      year      <= RESET_YEAR;
      cmd_load  <= 1'b0;
      cmd_down  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            if (load_ok) begin
              cmd_load <= 1'b1;
              busy     <= 1'b1;
              state    <= STEP;
            end else begin
              err <= 1'b1;
            end
          end else if (inc && !dec) begin
            cmd_load <= 1'b0;
            cmd_down <= 1'b0;
            busy     <= 1'b1;
            state    <= STEP;
          end else if (dec && !inc) begin
            cmd_load <= 1'b0;
            cmd_down <= 1'b1;
            busy     <= 1'b1;
            state    <= STEP;
          end
        end
        STEP: begin
          date      <= nxt_date;
          month     <= nxt_month;
          year      <= nxt_year;
          out_data  <= nxt_date;
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          state     <= EMIT_D;
        end
        EMIT_D: begin
          if (out_ready) begin
            out_data <= month;
            state    <= EMIT_M;
          end
        end
        EMIT_M: begin
          if (out_ready) begin
            out_data <= year;
            out_last <= 1'b1;
            state    <= EMIT_Y;
          end
        end
        EMIT_Y: begin
          if (out_ready) begin
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/date_stepper.md
# date_stepper

BCD calendar register that holds the current date, month and year, steps them forward or backward by one day with correct month, year and leap-year roll-over, and accepts direct loads. After every accepted change it emits the three BCD bytes as a date, month, year stream over a valid/ready handshake. The stream feeds the DS1302 write path and the day-info decoder, in the same byte order those blocks consume.

## Interface
- RESET_DATE, 8'h01, BCD date value after reset
- RESET_MONTH, 8'h01, BCD month value after reset
- RESET_YEAR, 8'h00, BCD year value after reset (00–99 means 2000–2099)

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- load  in  1  load pulse; captures load_date, load_month, load_year
- load_date / load_month / load_year  in  8 each  BCD values for load
- inc  in  1  step forward one day
- dec  in  1  step back one day
- date / month / year  out  8 each  current BCD registers
- busy  out  1  high from the accept edge until the last byte handshake
- err  out  1  one-cycle pulse when a load is rejected
- out_data  out  8  stream byte (BCD)
- out_valid  out  1  out_data is valid
- out_last  out  1  high with the year byte
- out_ready  in  1  downstream accepts the byte

## Operation
- FSM states: IDLE, STEP, EMIT_D, EMIT_M, EMIT_Y.
- Commands are sampled only in IDLE; any command seen while busy=1 is dropped.
- Command priority: load, then inc, then dec.
- inc and dec high together with load low: no command, no stream, state stays IDLE.
- Load validation:
  - month must be 01–12, year 00–99 with valid BCD nibbles, date 01–days_in_month(month, year).
  - An invalid load pulses err for one cycle, leaves the registers unchanged, emits no stream and stays in IDLE.
- Leap year: year mod 4 == 0, evaluated on the BCD digits. Either tens digit even with units 0/4/8, or tens digit odd with units 2/6.
- days_in_month:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February: 29 in a leap year, otherwise 28.
- inc rules:
  - date < days_in_month: date+1.
  - Otherwise date=01 and month+1.
  - Month 12 rolls to 01 and year+1; year 99 rolls to 00.
- dec rules:
  - date > 01: date−1.
  - Otherwise month−1 and date=days_in_month of the new month and year.
  - Month 01 rolls to 12 and year−1; year 00 rolls to 99.
- All BCD arithmetic is digit-wise; registers never hold a non-BCD nibble.
- STEP:
  - Commits the new date, month and year (or the loaded values) in one cycle.
  - Then moves to EMIT_D.
- Emit states:
  - EMIT_D drives date, EMIT_M drives month, EMIT_Y drives year with out_last=1.
  - Each state holds out_data and out_valid until out_valid && out_ready on a clock edge, then advances.
  - The EMIT_Y handshake returns the FSM to IDLE.

## Timing
- Reset values: date/month/year = RESET_*, out_valid=0, out_last=0, out_data=8'h00, busy=0, err=0, state IDLE.
- rst_n low at any point, including mid-stream, aborts the sequence immediately. No further bytes are emitted.
- Command accepted on edge N:
  - busy=1 and state STEP during cycle N+1.
  - Updated registers visible, out_valid=1 and out_data=date during cycle N+2.
- With out_ready held high:
  - Bytes are presented in cycles N+2, N+3, N+4.
  - busy=0 in cycle N+5.
  - The next command can be accepted on the edge ending cycle N+5.
- Rejected load on edge N: err=1 during cycle N+1 only; busy stays 0.
- out_data and out_valid are registered and must not change while out_valid=1 and out_ready=0.
- Back-pressure: out_ready may be low for any number of cycles in any emit state.

## Structure
- Package dateinfo_pkg holds:
  - BCD constants for months, 8'h28/8'h29/8'h30/8'h31 and 8'h99.
  - Functions bcd_inc, bcd_dec, leap_year and days_in_month (the leap-corrected version).
- The FSM state type also lives in dateinfo_pkg.
- One combinational sub-module, bcd_date_step, takes date/month/year plus a direction bit and produces the next date/month/year. date_stepper instantiates it once and muxes between its result and the load values.

## Test plan
- Reset with defaults → date/month/year = 01/01/00, out_valid=0, busy=0; first inc → stream 8'h02, 8'h01, 8'h00, with out_last on the 3rd byte.
- Load 28/02/23 then inc → 01/03/23; load 28/02/24 then inc → 29/02/24; a further inc → 01/03/24.
- Load 31/12/99 then inc → 01/01/00; dec → 31/12/99; load 01/03/24 then dec → 29/02/24.
- Load 30/02/23, then load 12/13/05, then load 1A/01/05 → err pulse for each, registers unchanged, no out_valid.
- Load 15/06/10 with out_ready low for 7 cycles in EMIT_M → out_data stays 8'h06 and out_valid stays high; inc pulses issued meanwhile are ignored; the stream completes 15, 06, 10.
- rst_n asserted during EMIT_M → out_valid=0 and registers = RESET_* immediately; no year byte afterwards.
